// File: rtl/calab_pkg.sv
// Shared types for the hazard scoreboard: pipeline entry, forwarding select, counter width.
package calab_pkg;

  localparam int unsigned REG_W       = 4;
  localparam int unsigned STALL_CNT_W = 16;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_match.sv
// Register-number comparator: asserts when the entry is a valid writer of reg_num.
module hazard_match
  import calab_pkg::*;
(
  input  logic [REG_W-1:0] reg_num,
  input  sb_entry_t        entry,
  output logic             match_c
);

  logic unused_c;

  assign match_c  = entry.valid & entry.wb_en & (entry.dest == reg_num);
  assign unused_c = ^{entry.mem_r, entry.src1, entry.src2, entry.two_src};

endmodule

// File: rtl/hazard_scoreboard.sv
// EXE/MEM/WB scoreboard producing the ID stall request, forwarding selects and a stall counter.
// FORWARDING_EN selects load-use-only stalling with MEM/WB forwarding; undefined = stall on any RAW.
module hazard_scoreboard
  import calab_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic [REG_W-1:0]       id_src1,
  input  logic [REG_W-1:0]       id_src2,
  input  logic                   id_two_src,
  input  logic                   id_wb_en,
  input  logic                   id_mem_r_en,
  input  logic [REG_W-1:0]       id_dest,
  output logic                   hazard,
  output logic [1:0]             fwd_sel_a,
  output logic [1:0]             fwd_sel_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  sb_entry_t              e_q, e_d, m_q, m_d, id_ent;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   s1_e, s2_e;

  hazard_match u_s1_e (.reg_num(id_src1), .entry(e_q), .match_c(s1_e));
  hazard_match u_s2_e (.reg_num(id_src2), .entry(e_q), .match_c(s2_e));

`ifdef FORWARDING_EN
  sb_entry_t w_q, w_d;
  logic      a_m, a_w, b_m, b_w;
  fwd_sel_t  fwd_a, fwd_b;

  hazard_match u_a_m (.reg_num(e_q.src1), .entry(m_q), .match_c(a_m));
  hazard_match u_a_w (.reg_num(e_q.src1), .entry(w_q), .match_c(a_w));
  hazard_match u_b_m (.reg_num(e_q.src2), .entry(m_q), .match_c(b_m));
  hazard_match u_b_w (.reg_num(e_q.src2), .entry(w_q), .match_c(b_w));

  // Only a load in EXE cannot be forwarded in time.
  assign hazard = e_q.mem_r & (s1_e | (id_two_src & s2_e));

  // MEM result has priority over WB; a load in MEM has no data yet.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (e_q.valid) begin
      if (a_m & ~m_q.mem_r)  fwd_a = FWD_MEM;
      else if (a_w)          fwd_a = FWD_WB;
      if (e_q.two_src) begin
        if (b_m & ~m_q.mem_r) fwd_b = FWD_MEM;
        else if (b_w)         fwd_b = FWD_WB;
      end
    end
  end

  assign fwd_sel_a = fwd_a;
  assign fwd_sel_b = fwd_b;

  always_comb begin
    w_d = w_q;
    if (!freeze) w_d = m_q;
  end

  always_ff @(posedge clk) begin
    if (rst) w_q <= '0;
    else     w_q <= w_d;
  end
`else
  logic s1_m, s2_m;

  hazard_match u_s1_m (.reg_num(id_src1), .entry(m_q), .match_c(s1_m));
  hazard_match u_s2_m (.reg_num(id_src2), .entry(m_q), .match_c(s2_m));

  // WB writes the regfile before ID reads it, so only EXE and MEM matter.
  assign hazard    = s1_e | s1_m | (id_two_src & (s2_e | s2_m));
  assign fwd_sel_a = FWD_RF;
  assign fwd_sel_b = FWD_RF;
`endif

  always_comb begin
    id_ent         = '0;
    id_ent.valid   = ~hazard & ~flush;
    id_ent.wb_en   = id_wb_en;
    id_ent.mem_r   = id_mem_r_en;
    id_ent.dest    = id_dest;
    id_ent.src1    = id_src1;
    id_ent.src2    = id_src2;
    id_ent.two_src = id_two_src;
  end

  // Advance the pipeline unless frozen; count unfrozen stall cycles without wrapping.
  always_comb begin
    e_d         = e_q;
    m_d         = m_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      e_d = id_ent;
      m_d = e_q;
      if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q         <= '0;
      m_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic vs. a queue-style model.
module tb_hazard_scoreboard;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, freeze, flush, id_two_src, id_wb_en, id_mem_r_en;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        hazard;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard(hazard), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit v; bit wb; bit mr; int d; int s1; int s2; bit two;
  } ment_t;

  ment_t       pipe[3];        // 0 = EXE, 1 = MEM, 2 = WB
  int unsigned stall_total;
  int          tests = 0;
  int          failed = 0;

  function automatic bit hits(int r, ment_t e);
    return e.v && e.wb && (e.d == r);
  endfunction

  function automatic bit exp_hazard();
    bit h = 1'b0;
    if (FWD) begin
      h = pipe[0].mr && (hits(int'(id_src1), pipe[0]) ||
                         (id_two_src && hits(int'(id_src2), pipe[0])));
    end else begin
      for (int k = 0; k < 2; k++)
        if (hits(int'(id_src1), pipe[k]) || (id_two_src && hits(int'(id_src2), pipe[k]))) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [1:0] exp_fwd(int r, bit used);
    if (!FWD || !pipe[0].v || !used) return 2'b00;
    if (hits(r, pipe[1]) && !pipe[1].mr) return 2'b01;
    if (hits(r, pipe[2])) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] exp_cnt();
    return (stall_total > 32'd65535) ? 16'hFFFF : 16'(stall_total);
  endfunction

  task automatic expect_val(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    expect_val({tag, ".hazard"}, int'(hazard), int'(exp_hazard()));
    expect_val({tag, ".fwd_a"}, int'(fwd_sel_a), int'(exp_fwd(int'(pipe[0].s1), 1'b1)));
    expect_val({tag, ".fwd_b"}, int'(fwd_sel_b), int'(exp_fwd(int'(pipe[0].s2), pipe[0].two)));
    expect_val({tag, ".stall_cnt"}, int'(stall_cnt), int'(exp_cnt()));
  endtask

  task automatic model_edge();
    bit h;
    h = exp_hazard();
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
      stall_total = 0;
    end else if (!freeze) begin
      if (h) stall_total++;
      pipe[2]     = pipe[1];
      pipe[1]     = pipe[0];
      pipe[0].v   = !h && !flush;
      pipe[0].wb  = id_wb_en;
      pipe[0].mr  = id_mem_r_en;
      pipe[0].d   = int'(id_dest);
      pipe[0].s1  = int'(id_src1);
      pipe[0].s2  = int'(id_src2);
      pipe[0].two = id_two_src;
    end
  endtask

  // Called at a negedge with inputs driven; ends at the next negedge.
  task automatic step(input string tag, input bit do_check);
    #1;
    if (do_check) check(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_id(input int s1, input int s2, input bit two, input bit wb,
                        input bit mr, input int dest);
    id_src1     = 4'(s1);
    id_src2     = 4'(s2);
    id_two_src  = two;
    id_wb_en    = wb;
    id_mem_r_en = mr;
    id_dest     = 4'(dest);
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step("idle", 1'b1);
  endtask

  initial begin
    int guard;
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    stall_total = 0;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step("rst", 1'b0);
    step("rst", 1'b0);
    rst = 1'b0;
    #1;
    expect_val("reset.hazard", int'(hazard), 0);
    expect_val("reset.fwd_a", int'(fwd_sel_a), 0);
    expect_val("reset.fwd_b", int'(fwd_sel_b), 0);
    expect_val("reset.stall_cnt", int'(stall_cnt), 0);
    idle(2);

    // ADD r1 then a reader of r1
    set_id(0, 0, 0, 1, 0, 1); step("add_issue", 1'b1);
    set_id(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("add_use", 1'b1);
    expect_val("add_use.total_stalls", int'(stall_cnt), FWD ? 0 : 2);
    idle(3);

    // LDR r2 then a two-source reader of r2
    set_id(0, 0, 0, 1, 1, 2); step("ldr_issue", 1'b1);
    set_id(0, 2, 1, 0, 0, 0);
    #1;
    expect_val("ldr_use.hazard", int'(hazard), 1);
    for (int i = 0; i < 3; i++) step("ldr_use", 1'b1);
    idle(3);

    // src2 match without two_src is not a read
    set_id(0, 0, 0, 1, 0, 3); step("one_src_issue", 1'b1);
    set_id(0, 3, 0, 0, 0, 0);
    #1;
    expect_val("one_src.hazard", int'(hazard), 0);
    step("one_src", 1'b1);
    idle(3);

    // Freeze while a hazard is pending
    set_id(0, 0, 0, 1, 1, 5); step("frz_issue", 1'b1);
    set_id(5, 0, 0, 0, 0, 0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step("freeze", 1'b1);
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) step("unfreeze", 1'b1);
    idle(3);

    // Flushed writer must not create a hazard
    set_id(0, 0, 0, 1, 1, 4); flush = 1'b1; step("flush", 1'b1);
    flush = 1'b0;
    set_id(4, 4, 1, 0, 0, 0);
    #1;
    expect_val("flush.hazard", int'(hazard), 0);
    step("flush_use", 1'b1);
    idle(3);

    // Random traffic with sparse freeze, flush and reset
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      set_id(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));
      step("rand", 1'b1);
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;

    // Saturation of the stall counter
    rst = 1'b1; set_id(0, 0, 0, 0, 0, 0); step("sat_rst", 1'b0);
    rst = 1'b0;
    set_id(1, 0, 0, 1, 1, 1);
    guard = 0;
    while (stall_total < 65540 && guard < 200000) begin
      step("sat", 1'b1);
      guard++;
    end
    expect_val("sat.budget", int'(stall_total >= 65540), 1);
    expect_val("sat.stall_cnt", int'(stall_cnt), 16'hFFFF);
    step("sat_more", 1'b1);
    rst = 1'b1; set_id(0, 0, 0, 0, 0, 0); step("sat_clear", 1'b0);
    rst = 1'b0;
    #1;
    expect_val("sat_clear.stall_cnt", int'(stall_cnt), 0);
    expect_val("sat_clear.hazard", int'(hazard), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
